shift_tx_ctrl: RTL and testbench

- Sequencer that feeds the 8-bit left shift register (clock C, clear CLR, serial in SI, serial out SO).
- Accepts parallel words from an upstream source over a valid/ready handshake and drives them MSB-first onto SI, one bit per C edge.
- Fills SI with 0 when there is no data to send.
- Tracks each bit through the shift register and flags when SO carries valid data and when a word's last bit leaves SO.
- Shares C and CLR with the shift register it controls.

---
 rtl/shift_tx_ctrl.sv | 169 ++++++++++++++++
 tb/tb_shift_tx_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_tx_ctrl.sv
// shift_tx_ctrl: sequencer that serialises parallel words MSB-first onto the SI
// input of a WIDTH-stage left shift register that shares its clock (C) and clear (CLR).
// It tracks every bit through the register, so it can flag when SO carries data
// and when the last bit of a word leaves SO.
//
// Ports:
//   C          clock, all state updates on posedge
//   CLR        asynchronous active-high clear (same net as the shift register's CLR)
//   din        parallel word to transmit
//   din_valid  upstream word present on din
//   din_ready  word on din is taken on this edge when din_valid is also high
//   SI         serial bit to the shift register (0 fill when idle)
//   so_valid   SO currently carries a data bit
//   done       one-cycle pulse: SO currently carries the LSB of a word
//   busy       a word is being shifted in, or data bits remain in the shift register
module shift_tx_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 0
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             SI,
  output logic             so_valid,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GCNT_W = 8;

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  PENULT   = CNT_W'(WIDTH - 2);
  // Only meaningful when GAP > 0; the GAP state is unreachable otherwise.
  localparam logic [GCNT_W-1:0] LAST_GAP = GCNT_W'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [GCNT_W-1:0]  gcnt, gcnt_n;
  logic [WIDTH-1:0]   hold, hold_n;
  logic               si_n;
  logic               si_valid, si_valid_n;
  logic               si_last, si_last_n;
  logic [WIDTH-1:0]   vsh, vsh_n;
  logic [WIDTH-1:0]   lsh, lsh_n;
  logic               din_ready_n;
  logic               busy_n;
  logic               accept;
  logic               load;

  // State and output registers.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      gcnt      <= '0;
      hold      <= '0;
      SI        <= 1'b0;
      si_valid  <= 1'b0;
      si_last   <= 1'b0;
      vsh       <= '0;
      lsh       <= '0;
      din_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      gcnt      <= gcnt_n;
      hold      <= hold_n;
      SI        <= si_n;
      si_valid  <= si_valid_n;
      si_last   <= si_last_n;
      vsh       <= vsh_n;
      lsh       <= lsh_n;
      din_ready <= din_ready_n;
      busy      <= busy_n;
    end
  end

  // Next state, serial datapath and per-bit tags for the bit going onto SI.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    gcnt_n     = gcnt;
    hold_n     = hold;
    si_n       = 1'b0;
    si_valid_n = 1'b0;
    si_last_n  = 1'b0;
    load       = 1'b0;
    accept     = din_valid & din_ready;

    case (state)
      ST_IDLE: begin
        load = accept;
      end
      ST_SHIFT: begin
        if (cnt == LAST_BIT) begin
          // LSB is on SI now: either open a gap or chain the next word with no bubble.
          if (GAP > 0) begin
            state_n = ST_GAP;
            gcnt_n  = '0;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          si_n       = hold[WIDTH-1];
          hold_n     = hold << 1;
          cnt_n      = cnt + 1'b1;
          si_valid_n = 1'b1;
          si_last_n  = (cnt == PENULT);
        end
      end
      ST_GAP: begin
        if (gcnt == LAST_GAP) begin
          if (accept) begin
            load = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Word load: MSB straight onto SI, remainder parked in hold.
    if (load) begin
      state_n    = ST_SHIFT;
      si_n       = din[WIDTH-1];
      hold_n     = din << 1;
      cnt_n      = '0;
      si_valid_n = 1'b1;
      si_last_n  = (WIDTH == 1);
    end
  end

  // Registered outputs derived from the next-cycle state.
  always_comb begin
    din_ready_n = 1'b0;
    case (state_n)
      ST_IDLE:  din_ready_n = 1'b1;
      ST_SHIFT: din_ready_n = (GAP == 0) && (cnt_n == LAST_BIT);
      ST_GAP:   din_ready_n = (gcnt_n == LAST_GAP);
      default:  din_ready_n = 1'b0;
    endcase

    // Shadow registers mirror the shift register so the tags exit alongside SO.
    vsh_n  = {vsh[WIDTH-2:0], si_valid};
    lsh_n  = {lsh[WIDTH-2:0], si_last};
    busy_n = (state_n != ST_IDLE) | si_valid_n | (|vsh_n);
  end

  assign so_valid = vsh[WIDTH-1];
  assign done     = lsh[WIDTH-1];

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Bench for shift_tx_ctrl: two instances (GAP=0 and GAP=3), each feeding its own
// 8-stage shift register model. A word-level reference model predicts handshakes,
// din_ready, busy and the timed SO/so_valid/done stream; a monitor checks every cycle.
module tb_shift_tx_ctrl;

  localparam int W    = 8;
  localparam int GAP0 = 0;
  localparam int GAP1 = 3;

  typedef struct {
    int   cyc;
    logic b;
    logic last;
  } exp_t;

  logic         C;
  logic         CLR;
  logic [W-1:0] din [2];
  logic         dv  [2];
  logic         rdy [2];
  logic         si  [2];
  logic         sov [2];
  logic         dn  [2];
  logic         bz  [2];
  logic [W-1:0] sr  [2];

  exp_t sb0[$];
  exp_t sb1[$];
  int   ncyc          = 0;
  int   n_vec         = 0;
  int   n_err         = 0;
  int   next_ok   [2] = '{0, 0};
  int   busy_until[2] = '{-1, -1};
  int   hs_cnt    [2] = '{0, 0};

  shift_tx_ctrl #(.WIDTH(W), .GAP(GAP0)) u_dut0 (
    .C(C), .CLR(CLR), .din(din[0]), .din_valid(dv[0]), .din_ready(rdy[0]),
    .SI(si[0]), .so_valid(sov[0]), .done(dn[0]), .busy(bz[0])
  );

  shift_tx_ctrl #(.WIDTH(W), .GAP(GAP1)) u_dut1 (
    .C(C), .CLR(CLR), .din(din[1]), .din_valid(dv[1]), .din_ready(rdy[1]),
    .SI(si[1]), .so_valid(sov[1]), .done(dn[1]), .busy(bz[1])
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // The controlled shift registers; SO is stage W-1.
  always @(posedge C or posedge CLR) begin
    if (CLR) begin
      sr[0] <= '0;
      sr[1] <= '0;
    end else begin
      sr[0] <= {sr[0][W-2:0], si[0]};
      sr[1] <= {sr[1][W-2:0], si[1]};
    end
  end

  function automatic int gap_of(input int l);
    return (l == 0) ? GAP0 : GAP1;
  endfunction

  task automatic chk(input string nm, input int l, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane%0d cyc%0d: got %0h, want %0h", nm, l, ncyc, act, exp);
    end
  endtask

  task automatic flush(input int l);
    if (l == 0) sb0.delete();
    else        sb1.delete();
    next_ok[l]    = 0;
    busy_until[l] = -1;
  endtask

  task automatic chk_reset(input int l);
    chk("ready_clr",    l, 8'(rdy[l]),    8'd1);
    chk("si_clr",       l, 8'(si[l]),     8'd0);
    chk("so_valid_clr", l, 8'(sov[l]),    8'd0);
    chk("done_clr",     l, 8'(dn[l]),     8'd0);
    chk("busy_clr",     l, 8'(bz[l]),     8'd0);
    chk("so_clr",       l, 8'(sr[l][W-1]), 8'd0);
  endtask

  task automatic chk_run(input int l);
    exp_t fr;
    bit   has;
    bit   due;
    has = 1'b0;
    fr  = '{cyc: 0, b: 1'b0, last: 1'b0};
    if (l == 0) begin
      if (sb0.size() > 0) begin has = 1'b1; fr = sb0[0]; end
    end else begin
      if (sb1.size() > 0) begin has = 1'b1; fr = sb1[0]; end
    end
    due = has && (fr.cyc == ncyc);
    chk("din_ready", l, 8'(ncyc + 1 >= next_ok[l]), 8'(rdy[l]) ^ 8'd0 ^ 8'd0);
    chk("busy",      l, 8'(bz[l]),  8'(ncyc <= busy_until[l]));
    chk("so_valid",  l, 8'(sov[l]), 8'(due));
    chk("done",      l, 8'(dn[l]),  8'(due ? fr.last : 1'b0));
    chk("so",        l, 8'(sr[l][W-1]), 8'(due ? fr.b : 1'b0));
    if (due) begin
      if (l == 0) void'(sb0.pop_front());
      else        void'(sb1.pop_front());
    end
  endtask

  // Predict a handshake on the coming posedge and schedule the word's SO bits.
  task automatic predict(input int l);
    exp_t         e;
    int           st;
    int           bu;
    logic [W-1:0] w;
    if (dv[l] === 1'b1 && (ncyc + 1 >= next_ok[l])) begin
      st = ncyc + 1;
      w  = din[l];
      for (int i = 0; i < W; i++) begin
        e.cyc  = st + W + i;
        e.b    = w[W-1-i];
        e.last = (i == W - 1);
        if (l == 0) sb0.push_back(e);
        else        sb1.push_back(e);
      end
      next_ok[l] = st + W + gap_of(l);
      bu = st + ((2*W - 1 > W + gap_of(l) - 1) ? 2*W - 1 : W + gap_of(l) - 1);
      if (bu > busy_until[l]) busy_until[l] = bu;
      hs_cnt[l]++;
    end
  endtask

  // Monitor: per-cycle checks at negedge, plus an immediate check when CLR rises mid-cycle.
  always @(negedge C or posedge CLR) begin
    if ($time != 0) begin
      if (C === 1'b1) begin
        #1;
        for (int l = 0; l < 2; l++) begin
          chk_reset(l);
          flush(l);
        end
      end else begin
        ncyc++;
        for (int l = 0; l < 2; l++) begin
          if (CLR) begin
            chk_reset(l);
            flush(l);
          end else begin
            chk_run(l);
            predict(l);
          end
        end
      end
    end
  end

  task automatic send(input int l, input logic [W-1:0] w, input bit keep);
    int h0;
    bit got;
    h0      = hs_cnt[l];
    got     = 1'b0;
    din[l]  = w;
    dv[l]   = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge C); #1;
      got = (hs_cnt[l] != h0);
    end
    if (!got) begin
      $display("FAIL send_timeout lane%0d: got no handshake, want word %0h accepted", l, w);
      $fatal(1, "handshake timeout");
    end
    if (!keep) dv[l] = 1'b0;
  endtask

  task automatic wait_idle(input int l);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 600 && !idle; k++) begin
      idle = (l == 0 ? sb0.size() == 0 : sb1.size() == 0) && (ncyc > busy_until[l]);
      if (!idle) begin @(posedge C); #1; end
    end
    if (!idle) begin
      $display("FAIL idle_timeout lane%0d: got still busy, want idle", l);
      $fatal(1, "idle timeout");
    end
    repeat (2) begin @(posedge C); #1; end
  endtask

  initial begin
    int         l;
    int         k;
    bit         keep;
    logic [W-1:0] w;

    // Clear held with a word offered: ignored until release, then taken on the first edge.
    CLR    = 1'b1;
    dv[0]  = 1'b1;  dv[1]  = 1'b1;
    din[0] = 8'hFF; din[1] = 8'hFF;
    repeat (3) @(posedge C);
    #1 CLR = 1'b0;
    @(posedge C); #1;
    dv[0] = 1'b0; dv[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);

    // Single word.
    send(0, 8'hA5, 1'b0);
    wait_idle(0);

    // Back-to-back with din_valid held.
    send(0, 8'hFF, 1'b1);
    send(0, 8'h00, 1'b0);
    wait_idle(0);

    // Back-to-back through a 3-cycle gap.
    send(1, 8'h81, 1'b1);
    send(1, 8'h81, 1'b0);
    wait_idle(1);

    // Next word offered mid-word.
    send(0, 8'hC3, 1'b0);
    repeat (3) @(posedge C);
    #1;
    send(0, 8'h5A, 1'b0);
    wait_idle(0);

    // Clear after four bits, then a clean word.
    send(0, 8'hF0, 1'b0);
    repeat (4) @(posedge C);
    #1 CLR = 1'b1;
    repeat (2) @(posedge C);
    #1 CLR = 1'b0;
    send(0, 8'h3C, 1'b0);
    wait_idle(0);

    // Random traffic on both lanes.
    for (int it = 0; it < 40; it++) begin
      l    = int'($urandom_range(0, 1));
      w    = W'($urandom);
      keep = 1'($urandom_range(0, 1));
      send(l, w, keep);
      if (!keep) begin
        k = int'($urandom_range(0, 3));
        repeat (k) begin @(posedge C); #1; end
      end
    end
    dv[0] = 1'b0;
    dv[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
